// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction RAM write port of the boot loader
interface imem_loader_if #(
    parameter int width       = 16,
    parameter int iaddr_width = 10
);
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;
    logic [iaddr_width-1:0] imem_addr;
    logic [width-1:0]       imem_data;
    logic                   imem_write;
    modport master (output in_valid, in_data, input in_ready, imem_addr, imem_data, imem_write);
    modport slave  (input in_valid, in_data, output in_ready, imem_addr, imem_data, imem_write);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a framed, checksummed program image and writes it into instruction RAM,
// holding the CPU in reset until a good image has loaded
module imem_loader #(
    parameter int         width       = 16,
    parameter int         iaddr_width = 10,
    parameter logic [7:0] SYNC        = 8'hA5
) (
    input  logic         clk,
    input  logic         reset_n,
    imem_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         busy,
    output logic         done,
    output logic         error
);
    typedef enum logic [2:0] {WAIT_SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, RUN} state_t;
    localparam int cw = iaddr_width + 1;
    state_t          state, state_n;
    logic [7:0]      len_lo, lo, csum;
    logic [cw-1:0]   cnt, len, cnt_inc;
    logic [15:0]     n;
    logic            ready, xfer, is_sync, too_long, csum_ok;
    assign ready        = 1'b1;
    assign bus.in_ready = ready;
    assign xfer         = bus.in_valid && ready;
    assign is_sync      = bus.in_data == SYNC;
    assign n            = {bus.in_data, len_lo};
    assign too_long     = 32'(n) > (32'd1 << iaddr_width);
    assign cnt_inc      = cnt + 1'b1;
    assign csum_ok      = bus.in_data == csum;
    assign busy         = state != WAIT_SYNC && state != RUN;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= WAIT_SYNC;
        else          state <= state_n;
    always_comb begin
        state_n = state;
        if (xfer)
            case (state)
                WAIT_SYNC, RUN: state_n = is_sync ? LEN_LO : state;
                LEN_LO:         state_n = LEN_HI;
                LEN_HI:         state_n = too_long ? WAIT_SYNC : n == 16'd0 ? CSUM : DATA_LO;
                DATA_LO:        state_n = DATA_HI;
                DATA_HI:        state_n = cnt_inc == len ? CSUM : DATA_LO;
                CSUM:           state_n = csum_ok ? RUN : WAIT_SYNC;
                default:        state_n = WAIT_SYNC;
            endcase
    end
    // The RAM write is a pipeline stage one cycle behind the high byte, so input never stalls
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cpu_reset      <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            csum           <= '0;
            cnt            <= '0;
            len            <= '0;
            len_lo         <= '0;
            lo             <= '0;
            bus.imem_write <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_data  <= '0;
        end else begin
            cpu_reset      <= state_n != RUN;
            bus.imem_write <= 1'b0;
            if (xfer)
                case (state)
                    WAIT_SYNC, RUN: if (is_sync) begin
                        csum  <= '0;
                        cnt   <= '0;
                        done  <= 1'b0;
                        error <= 1'b0;
                    end
                    LEN_LO: begin
                        len_lo <= bus.in_data;
                        csum   <= csum ^ bus.in_data;
                    end
                    LEN_HI: begin
                        len   <= n[cw-1:0];
                        csum  <= csum ^ bus.in_data;
                        error <= too_long;
                    end
                    DATA_LO: begin
                        lo   <= bus.in_data;
                        csum <= csum ^ bus.in_data;
                    end
                    DATA_HI: begin
                        csum           <= csum ^ bus.in_data;
                        cnt            <= cnt_inc;
                        bus.imem_write <= 1'b1;
                        bus.imem_addr  <= cnt[iaddr_width-1:0];
                        bus.imem_data  <= width'({bus.in_data, lo});
                    end
                    CSUM: begin
                        done  <= csum_ok;
                        error <= !csum_ok;
                    end
                    default: ;
                endcase
        end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames with gaps and garbage, checked against a frame-level model
module tb_imem_loader;
    localparam int iw = 10;
    localparam int w  = 16;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic cpu_reset, busy, done, error;
    int checks = 0;
    int errors = 0;
    logic [25:0] got[$];
    logic [25:0] exp[$];
    logic [15:0] words[0:1023];
    imem_loader_if #(.width(w), .iaddr_width(iw)) bus ();
    imem_loader #(.width(w), .iaddr_width(iw)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (reset_n && bus.imem_write) got.push_back({bus.imem_addr, bus.imem_data});
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, req);
        end
    endtask
    task automatic send(input logic [7:0] b, input int gap_max);
        int g;
        g = $urandom_range(0, gap_max);
        if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask
    task automatic compare_writes();
        check("nwrites", got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++) check("write", got[i], exp[i]);
    endtask
    // Model: a frame of n words either fails on length (no writes) or writes every word
    // in order at addresses 0..n-1 and then succeeds iff the checksum byte is the XOR of the rest
    task automatic run_frame(input int n, input logic [7:0] cx, input int gap_max, input int garbage);
        logic [7:0] cs, gb;
        got.delete();
        exp.delete();
        for (int k = 0; k < garbage; k++) begin
            gb = k == 0 ? 8'h00 : k == 1 ? 8'hFF : 8'($urandom_range(0, 255));
            send(gb == 8'hA5 ? 8'h5A : gb, gap_max);
        end
        send(8'hA5, gap_max);
        send(n[7:0], gap_max);
        send(n[15:8], gap_max);
        if (n > (1 << iw)) begin
            check("len_err", {busy, error, done, cpu_reset}, 4'b0101);
        end else begin
            cs = n[7:0] ^ n[15:8];
            for (int k = 0; k < n; k++) begin
                send(words[k][7:0], gap_max);
                send(words[k][15:8], gap_max);
                cs ^= words[k][7:0] ^ words[k][15:8];
                exp.push_back({k[9:0], words[k]});
            end
            check("pre_csum", {busy, cpu_reset}, 2'b11);
            send(cs ^ cx, gap_max);
            check("result", {busy, done, error, cpu_reset}, cx == 8'h00 ? 4'b0100 : 4'b0011);
        end
        repeat (2) @(posedge clk);
        #1;
        compare_writes();
    endtask
    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", {bus.in_ready, cpu_reset, bus.imem_write, busy, done, error}, 6'b110000);
        check("reset_bus", {bus.imem_addr, bus.imem_data}, 26'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        run_frame(2, 8'h00, 0, 0);
        run_frame(2, 8'h01, 0, 0);
        run_frame(16'h0401, 8'h00, 0, 0);
        run_frame(2, 8'h00, 0, 0);
        run_frame(0, 8'h02, 0, 0);
        run_frame(0, 8'h00, 0, 0);
        run_frame(2, 8'h00, 5, 2);
        for (int k = 0; k < 1024; k++) words[k] = 16'($urandom);
        run_frame(1024, 8'h00, 0, 0);
        run_frame(1025, 8'h00, 1, 1);
        run_frame(1, 8'h00, 0, 0);
        // Live reload from RUN, then an asynchronous reset part-way through the data
        got.delete();
        send(8'hA5, 0);
        check("reload", {cpu_reset, busy, done}, 3'b110);
        send(8'h03, 0);
        send(8'h00, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        reset_n = 1'b0;
        #1;
        check("abort_out", {bus.in_ready, cpu_reset, bus.imem_write, busy, done, error}, 6'b110000);
        check("abort_bus", {bus.imem_addr, bus.imem_data}, 26'd0);
        check("abort_nw", got.size(), 1);
        check("abort_w0", got[0], {10'd0, 16'h2211});
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send(8'h44, 0);
        send(8'h55, 0);
        send(8'h66, 0);
        send(8'h77, 0);
        repeat (2) @(posedge clk);
        #1;
        check("post_abort_nw", got.size(), 1);
        check("post_abort", {busy, done, error, cpu_reset}, 4'b0001);
        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(0, 7) == 0 ? 1025 + $urandom_range(0, 64000) : $urandom_range(0, 8);
            for (int k = 0; k < 8; k++) words[k] = 16'($urandom);
            run_frame(n, $urandom_range(0, 3) == 0 ? 8'($urandom_range(1, 255)) : 8'h00,
                      5, $urandom_range(0, 3));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the CPU's instruction memory; the CPU core is the reader of the same memory through iaddr/idata.
- Receives a framed program image as a byte stream (valid/ready) and assembles little-endian 16-bit words.
- Writes the words into instruction RAM through a dedicated write port and holds the CPU in reset until a checksummed image has loaded.
- Sits between the host byte source (UART receiver) and the instruction RAM write port / CPU reset input.

Parameters:
- width, 16, instruction word width; the loader assembles 2 bytes per word, so width must be 16.
- iaddr_width, 10, instruction address width; maximum image length is 2**iaddr_width words.
- SYNC, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte available from source.
- in_data  input  8  byte from source.
- in_ready  output  1  loader accepts the byte; a transfer occurs when in_valid && in_ready.
- imem_addr  output  iaddr_width  instruction RAM write address.
- imem_data  output  width  instruction RAM write data.
- imem_write  output  1  one-cycle write strobe.
- cpu_reset  output  1  active-high reset to the CPU core.
- busy  output  1  frame in progress (any state other than WAIT_SYNC/RUN).
- done  output  1  last frame loaded successfully.
- error  output  1  last frame failed (length or checksum).

Behaviour:
- Frame format: SYNC, LEN_LO, LEN_HI, then N words each sent LO byte then HI byte, then CSUM.
- N = {LEN_HI, LEN_LO}.
- CSUM must equal the XOR of LEN_LO, LEN_HI and all data bytes. SYNC is excluded.
- Reset values:
  - state = WAIT_SYNC, in_ready = 1, cpu_reset = 1.
  - imem_write = 0, imem_addr = 0, imem_data = 0.
  - busy = 0, done = 0, error = 0.
  - word counter = 0, checksum accumulator = 0.
- States: WAIT_SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, RUN.
- in_ready is 1 in every state, so the loader never back-pressures.
- Bytes are only consumed on the in_valid && in_ready cycle. A state with no transfer holds.
- WAIT_SYNC:
  - Byte == SYNC -> LEN_LO; clear checksum, counter, done and error.
  - Any other byte is discarded.
- LEN_LO: latch the low length byte, XOR it into the checksum -> LEN_HI.
- LEN_HI: latch the high byte, XOR it into the checksum.
  - N > 2**iaddr_width -> WAIT_SYNC with error = 1.
  - N == 0 -> CSUM.
  - Otherwise -> DATA_LO.
- DATA_LO: hold the byte, XOR it into the checksum -> DATA_HI.
- DATA_HI: XOR the byte into the checksum.
  - Next cycle: imem_write = 1 for exactly one cycle, imem_addr = counter[iaddr_width-1:0], imem_data = {hi, lo}.
  - The counter (iaddr_width+1 bits) increments.
  - If the incremented counter == N -> CSUM, else -> DATA_LO.
  - Back-to-back bytes are legal: the write is a registered pipeline stage and never stalls input.
- CSUM:
  - Byte == accumulator -> RUN; done = 1; cpu_reset deasserts the following cycle.
  - Mismatch -> WAIT_SYNC with error = 1 and cpu_reset still 1.
  - The last data-word write may coincide with the CSUM byte transfer; both complete.
- RUN:
  - cpu_reset = 0.
  - A SYNC byte reasserts cpu_reset on the next cycle and goes to LEN_LO (live reload).
  - Other bytes are discarded.
- cpu_reset is 1 in every state except RUN. It is registered and glitch-free.
- busy = 1 in LEN_LO through CSUM.
- done and error are never both 1. Both clear on the next accepted SYNC.
- A SYNC value appearing inside the length, data or checksum fields is treated as data; there is no resync mid-frame.
- A reset_n assertion mid-frame aborts immediately:
  - all outputs return to their reset values;
  - any pending write strobe is dropped;
  - the partially written RAM contents are left as is.
- Counter and address never wrap, because N ≤ 2**iaddr_width is enforced at LEN_HI.

Test Plan:
- Bytes A5 02 00 34 12 CD AB 42 sent back-to-back -> write 0x1234 at address 0, then 0xABCD at address 1, each strobe exactly 1 cycle. Then done = 1, error = 0, and cpu_reset falls one cycle after the 0x42 byte.
- Same frame with CSUM 0x43 -> both writes occur, then error = 1, done = 0, cpu_reset stays 1, state returns to WAIT_SYNC.
- A5 01 04 (N = 0x0401) with default parameters -> error = 1 right after LEN_HI, no writes; then a valid frame loads correctly and clears error.
- A5 00 00 02 (N = 0; CSUM = 0x00 ^ 0x00 = 0x00, so 0x02 mismatches) -> no writes, error = 1. Repeat with CSUM 0x00 -> done = 1, cpu_reset = 0.
- Random in_valid gaps (0–5 idle cycles) and leading garbage bytes 0x00, 0xFF before SYNC -> identical writes and result to the back-to-back case.
- In RUN, send A5 -> cpu_reset = 1 the next cycle. Assert reset_n low after the third data byte -> all outputs return to reset values and no further writes occur.
